// File: rtl/adder4_accumulator.sv
// adder4_accumulator
//   Sequential stage wrapped around an external 4-bit ripple adder (Adder4).
//   Operands arrive over a valid/ready handshake. The accumulator register
//   drives the adder's A input and the incoming nibble drives B, with Cin tied
//   low. Each accepted Sum is registered back into the accumulator and each
//   Cout is counted. After COUNT_N operands the frame total {carries, acc} is
//   presented downstream until the consumer takes it.
//
// Parameters
//   COUNT_N  operands per frame (1..15)
//   CARRY_W  width of the carry counter; out_sum is 4+CARRY_W bits wide
//
// Configuration macro
//   ADDER4_ACC_SAT_EN  defined: carry counter saturates at all-ones
//                      undefined: carry counter wraps modulo 2^CARRY_W
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand valid
//   in_ready   stage can accept an operand (registered)
//   in_data    operand nibble
//   add_a      to Adder4 A: accumulator register
//   add_b      to Adder4 B: in_data pass-through
//   add_cin    to Adder4 Cin: constant 0
//   add_sum    from Adder4 Sum
//   add_cout   from Adder4 Cout
//   out_valid  frame result valid (registered)
//   out_ready  downstream accepts the result
//   out_sum    {carry_cnt, acc} frame total (registered)

module adder4_accumulator #(
  parameter int COUNT_N = 4,
  parameter int CARRY_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_data,
  output logic [3:0]         add_a,
  output logic [3:0]         add_b,
  output logic               add_cin,
  input  logic [3:0]         add_sum,
  input  logic               add_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CARRY_W+3:0] out_sum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(COUNT_N - 1);

  state_t             state_r;
  logic [3:0]         acc_r;
  logic [CARRY_W-1:0] carry_cnt_r;
  logic [3:0]         beat_cnt_r;
  logic               accept_s;
  logic [CARRY_W-1:0] carry_next_s;

  // Next carry count for one adder result: saturating or wrapping.
  function automatic logic [CARRY_W-1:0] carry_step(
    input logic [CARRY_W-1:0] cnt,
    input logic               cout
  );
`ifdef ADDER4_ACC_SAT_EN
    if (cout && (cnt != {CARRY_W{1'b1}})) begin
      return cnt + CARRY_W'(1'b1);
    end else begin
      return cnt;
    end
`else
    return cnt + CARRY_W'(cout);
`endif
  endfunction

  // The adder sees the accumulator and the raw operand; nothing else sits on
  // the in_data -> add_sum -> acc path besides the enable below.
  assign add_a   = acc_r;
  assign add_b   = in_data;
  assign add_cin = 1'b0;

  assign accept_s     = in_valid & in_ready;
  assign carry_next_s = carry_step(carry_cnt_r, add_cout);

  // Frame FSM with accumulator, carry/beat counters and registered handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= 4'd0;
      carry_cnt_r <= {CARRY_W{1'b0}};
      beat_cnt_r  <= 4'd0;
      out_valid   <= 1'b0;
      out_sum     <= {(CARRY_W+4){1'b0}};
      in_ready    <= 1'b1;
    end else begin
      case (state_r)
        IDLE, ACCUM: begin
          if (accept_s) begin
            acc_r       <= add_sum;
            carry_cnt_r <= carry_next_s;
            beat_cnt_r  <= beat_cnt_r + 4'd1;
            if (beat_cnt_r == LAST_BEAT) begin
              // Last operand: capture the total from the values being
              // written this edge, not the stale registers.
              state_r   <= DONE;
              out_sum   <= {carry_next_s, add_sum};
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end else begin
              state_r <= ACCUM;
            end
          end else begin
            state_r <= state_r;
          end
        end
        DONE: begin
          if (out_ready) begin
            // Result handed off: start the next frame from zero; out_sum
            // keeps its last value.
            state_r     <= IDLE;
            acc_r       <= 4'd0;
            carry_cnt_r <= {CARRY_W{1'b0}};
            beat_cnt_r  <= 4'd0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          acc_r       <= 4'd0;
          carry_cnt_r <= {CARRY_W{1'b0}};
          beat_cnt_r  <= 4'd0;
          out_valid   <= 1'b0;
          in_ready    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder4_accumulator.sv
module tb_adder4_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, add_cin, add_cout, out_valid, out_ready;
  logic [3:0] in_data, add_a, add_b, add_sum;
  logic [7:0] out_sum;

  // Second instance: COUNT_N=15, CARRY_W=2
  logic       in_valid6, in_ready6, add_cin6, add_cout6, out_valid6, out_ready6;
  logic [3:0] in_data6, add_a6, add_b6, add_sum6;
  logic [5:0] out_sum6;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Behavioural Adder4 for each instance
  assign {add_cout, add_sum}   = 5'(add_a)  + 5'(add_b)  + 5'(add_cin);
  assign {add_cout6, add_sum6} = 5'(add_a6) + 5'(add_b6) + 5'(add_cin6);

  adder4_accumulator u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum)
  );

  adder4_accumulator #(.COUNT_N(15), .CARRY_W(2)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6),
    .in_data(in_data6), .add_a(add_a6), .add_b(add_b6), .add_cin(add_cin6),
    .add_sum(add_sum6), .add_cout(add_cout6), .out_valid(out_valid6),
    .out_ready(out_ready6), .out_sum(out_sum6)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand and hold it until accepted (bounded wait).
  task automatic accept_beat(input logic [3:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check_eq("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [5:0] exp6;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
    in_valid6 = 1'b0; in_data6 = 4'd0; out_ready6 = 1'b0;
    tick();
    // Reset state
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_sum",   {24'd0, out_sum},   32'd0);
    check_eq("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check_eq("rst_add_a",     {28'd0, add_a},     32'd0);
    check_eq("rst_add_cin",   {31'd0, add_cin},   32'd0);
    rst = 1'b0;
    tick();

    // 1: 3,5,7,9 back-to-back -> 0x18 (held via backpressure for scenario 3)
    in_data = 4'hA;
    #1 check_eq("add_b_pass", {28'd0, add_b}, 32'hA);
    accept_beat(4'd3);
    accept_beat(4'd5);
    accept_beat(4'd7);
    check_eq("s1_no_early_valid", {31'd0, out_valid}, 32'd0);
    accept_beat(4'd9);
    check_eq("s1_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("s1_out_sum",   {24'd0, out_sum},   32'h18);

    // 3: backpressure, in_valid high, 5 cycles
    in_valid = 1'b1; in_data = 4'd6;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("s3_hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("s3_hold_sum",   {24'd0, out_sum},   32'h18);
      check_eq("s3_in_ready",   {31'd0, in_ready},  32'd0);
    end
    check_eq("s3_acc_untouched", {28'd0, add_a}, 32'h8);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("s3_release_valid", {31'd0, out_valid}, 32'd0);
    check_eq("s3_release_ready", {31'd0, in_ready},  32'd1);
    check_eq("s3_release_acc",   {28'd0, add_a},     32'd0);
    check_eq("s3_sum_kept",      {24'd0, out_sum},   32'h18);

    // 2: 15,15,15,15 -> add_a 0,15,14,13; out_sum 0x3C
    in_data = 4'd15; in_valid = 1'b1;
    #1 check_eq("s2_add_a0", {28'd0, add_a}, 32'd0);
    tick();
    check_eq("s2_add_a1", {28'd0, add_a}, 32'd15);
    tick();
    check_eq("s2_add_a2", {28'd0, add_a}, 32'd14);
    tick();
    check_eq("s2_add_a3", {28'd0, add_a}, 32'd13);
    tick();
    in_valid = 1'b0;
    check_eq("s2_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("s2_out_sum",   {24'd0, out_sum},   32'h3C);
    tick();
    check_eq("s2_consumed", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // 4: 1,2,3,4 with 2-cycle bubbles -> 0x0A
    for (int i = 1; i <= 4; i++) begin
      accept_beat(4'(i));
      if (i < 4) begin
        tick();
        tick();
        check_eq("s4_bubble_acc",   {28'd0, add_a},     32'((i * (i + 1)) / 2));
        check_eq("s4_bubble_valid", {31'd0, out_valid}, 32'd0);
      end
    end
    check_eq("s4_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("s4_out_sum",   {24'd0, out_sum},   32'h0A);
    out_ready = 1'b1;
    tick();

    // 5: reset mid-frame, then 1,1,1,1 -> 0x04
    accept_beat(4'd9);
    accept_beat(4'd9);
    do_reset();
    check_eq("s5_rst_acc", {28'd0, add_a}, 32'd0);
    accept_beat(4'd1);
    accept_beat(4'd1);
    accept_beat(4'd1);
    check_eq("s5_no_early_valid", {31'd0, out_valid}, 32'd0);
    accept_beat(4'd1);
    check_eq("s5_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("s5_out_sum",   {24'd0, out_sum},   32'h04);
    tick();

    // 6: COUNT_N=15, CARRY_W=2, fifteen 15s: sum 225 = 14 carries, acc 1
`ifdef ADDER4_ACC_SAT_EN
    exp6 = {2'd3, 4'd1};
`else
    exp6 = {2'd2, 4'd1};
`endif
    in_valid6 = 1'b1; in_data6 = 4'd15;
    for (int i = 0; i < 14; i++) tick();
    check_eq("s6_no_early_valid", {31'd0, out_valid6}, 32'd0);
    tick();
    in_valid6 = 1'b0;
    check_eq("s6_out_valid", {31'd0, out_valid6}, 32'd1);
    check_eq("s6_out_sum",   {26'd0, out_sum6},   {26'd0, exp6});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
